racket_pos_ctl: RTL and testbench
=================================

RACKET_POS_CTL -- requirements
Module: racket_pos_ctl

Interface
REQ-001 SHALL have parameter Y_MIN, default 51, top limit of racket top edge.
REQ-002 SHALL have parameter Y_MAX, default 717, bottom limit of racket bottom edge.
REQ-003 SHALL have parameter RACKET_H, default 80, racket height in lines.
REQ-004 SHALL have parameter AI_STEP, default 4, max single-mode player-2 move per frame in lines.
REQ-005 SHALL have parameter TIMEOUT_FRAMES, default 64, frames without remote update before timeout.
REQ-006 SHALL have ports: clk65MHz in 1 clock; rst in 1 reset, synchronous, active-high.
REQ-007 SHALL have ports: vblnk in 1 vertical blank from timing chain; mouse_ypos in 12 local mouse Y; remote_pos in 10 player-2 Y from link; remote_valid in 1 one-cycle strobe qualifying remote_pos.
REQ-008 SHALL have ports: screen_idle in 1; screen_single in 1; ball_ypos in 10 ball centre Y.
REQ-009 SHALL have ports: p1_ypos out 10 racket-1 top Y; p2_ypos out 10 racket-2 top Y; pos_valid out 1 update pulse; remote_timeout out 1 link-loss flag; mode out 2 state (00 IDLE, 01 SINGLE, 10 MULTI).

Function
REQ-010 SHALL define TOP_MAX = Y_MAX - RACKET_H (637) and CENTRE = (Y_MIN + TOP_MAX)/2 (344).
REQ-011 SHALL register vblnk once; frame strobe = vblnk high and registered vblnk low (rising edge), one cycle wide.
REQ-012 SHALL change p1_ypos, p2_ypos, mode only at the clock edge following a frame strobe cycle, with pos_valid high for exactly that one cycle.
REQ-013 SHALL clamp all positions: value < Y_MIN -> Y_MIN; value > TOP_MAX -> TOP_MAX; compare at full 12-bit width.
REQ-014 SHALL set p1_ypos = clamp(mouse_ypos) in SINGLE and MULTI.
REQ-015 SHALL in SINGLE compute target = clamp(ball_ypos - RACKET_H/2), negative difference treated as Y_MIN; move p2_ypos toward target by min(|target - p2_ypos|, AI_STEP); equal -> no change.
REQ-016 SHALL in MULTI latch remote_pos into a holding register on every remote_valid; at strobe p2_ypos = clamp(holding); remote_valid coincident with strobe SHALL use the new remote_pos.
REQ-017 SHALL count frame strobes in MULTI since last remote_valid; at count = TIMEOUT_FRAMES set remote_timeout = 1 and hold p2_ypos; counter saturates.
REQ-018 SHALL clear remote_timeout and counter on the cycle after any remote_valid, and on leaving MULTI.
REQ-019 SHALL implement FSM IDLE/SINGLE/MULTI, evaluated only at frame strobe: screen_idle=1 -> IDLE (priority); else screen_single=1 -> SINGLE; else MULTI.
REQ-020 SHALL on any state change load p1_ypos = p2_ypos = CENTRE for that frame instead of normal update.
REQ-021 SHALL in IDLE hold p1_ypos = p2_ypos = CENTRE and still pulse pos_valid each frame.
REQ-022 SHALL ignore mode input changes between strobes.

Reset
REQ-023 SHALL on rst: mode = IDLE, p1_ypos = p2_ypos = CENTRE, holding register = CENTRE, pos_valid = 0, remote_timeout = 0, counter = 0, registered vblnk = 0.
REQ-024 SHALL treat rst asserted mid-frame as abort: no pos_valid until a strobe after rst release; vblnk already high at release SHALL NOT generate a strobe.

Verification
REQ-025 Reset, then screen_single=1, one strobe -> mode 01, p1=p2=344, pos_valid one cycle after strobe.
REQ-026 SINGLE, mouse_ypos 10 / 700 / 300 over three strobes -> p1_ypos 51 / 637 / 300.
REQ-027 SINGLE, p2=344, ball_ypos 500 (target 460) -> p2 348, 352, ... reaching 460 after 29 frames then stable.
REQ-028 MULTI, remote_valid with remote_pos 600 same cycle as strobe -> p2_ypos 600 next cycle; remote_pos 5 -> 51.
REQ-029 MULTI, no remote_valid for 64 strobes -> remote_timeout=1 after 64th, p2 held; one remote_valid -> flag 0 next cycle.
REQ-030 screen_idle and screen_single both toggled mid-frame, then screen_idle=1 at strobe -> no change before strobe, then mode 00, p1=p2=344.

Source files
------------

// File: rtl/racket_pos_ctl.sv
// Racket position controller: per-frame update of both racket top edges from mouse,
// ball-tracking AI or remote link, with a small IDLE/SINGLE/MULTI mode FSM.
//
// state  | meaning
// IDLE   | both rackets parked at CENTRE, pos_valid still pulses each frame
// SINGLE | p1 from mouse, p2 chases ball at up to AI_STEP lines per frame
// MULTI  | p1 from mouse, p2 from remote link with link-loss timeout
module racket_pos_ctl #(
  parameter int Y_MIN          = 51,
  parameter int Y_MAX          = 717,
  parameter int RACKET_H       = 80,
  parameter int AI_STEP        = 4,
  parameter int TIMEOUT_FRAMES = 64
) (
  input  logic        clk65MHz,
  input  logic        rst,
  input  logic        vblnk,
  input  logic [11:0] mouse_ypos,
  input  logic [9:0]  remote_pos,
  input  logic        remote_valid,
  input  logic        screen_idle,
  input  logic        screen_single,
  input  logic [9:0]  ball_ypos,
  output logic [9:0]  p1_ypos,
  output logic [9:0]  p2_ypos,
  output logic        pos_valid,
  output logic        remote_timeout,
  output logic [1:0]  mode
);

  localparam int TOP_MAX = Y_MAX - RACKET_H;
  localparam int CENTRE  = (Y_MIN + TOP_MAX) / 2;
  localparam int CW      = $clog2(TIMEOUT_FRAMES + 1);

  localparam logic [11:0]   LIM_LO = 12'(Y_MIN);
  localparam logic [11:0]   LIM_HI = 12'(TOP_MAX);
  localparam logic [11:0]   HALF_H = 12'(RACKET_H / 2);
  localparam logic [9:0]    POS_LO = 10'(Y_MIN);
  localparam logic [9:0]    POS_HI = 10'(TOP_MAX);
  localparam logic [9:0]    POS_C  = 10'(CENTRE);
  localparam logic [9:0]    STEP   = 10'(AI_STEP);
  localparam logic [CW-1:0] T_MAX  = CW'(TIMEOUT_FRAMES);

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] SINGLE = 2'b01;
  localparam logic [1:0] MULTI  = 2'b10;

  logic          vblnk_q;
  logic          strobe_armed;
  logic          strobe;
  logic [9:0]    hold;
  logic [CW-1:0] cnt;
  logic [1:0]    mode_next;
  logic [11:0]   ball_w;
  logic [9:0]    ai_target;
  logic [9:0]    ai_diff;
  logic [9:0]    ai_next;
  logic          timeout_hit;

  function automatic logic [9:0] clamp(input logic [11:0] v);
    if (v < LIM_LO)      clamp = POS_LO;
    else if (v > LIM_HI) clamp = POS_HI;
    else                 clamp = v[9:0];
  endfunction

  // vblnk must be seen low after reset before an edge counts, so a release
  // in the middle of a blanking interval does not fire a spurious frame.
  assign strobe = vblnk && !vblnk_q && strobe_armed;

  assign ball_w      = {2'b00, ball_ypos};
  assign timeout_hit = remote_timeout || (cnt == T_MAX - 1'b1);

  always_comb begin
    mode_next = MULTI;
    if (screen_idle)        mode_next = IDLE;
    else if (screen_single) mode_next = SINGLE;
  end

  always_comb begin
    ai_target = POS_LO;
    if (ball_w >= HALF_H) ai_target = clamp(ball_w - HALF_H);
    ai_diff = '0;
    ai_next = p2_ypos;
    if (ai_target > p2_ypos) begin
      ai_diff = ai_target - p2_ypos;
      ai_next = (ai_diff > STEP) ? p2_ypos + STEP : ai_target;
    end else if (ai_target < p2_ypos) begin
      ai_diff = p2_ypos - ai_target;
      ai_next = (ai_diff > STEP) ? p2_ypos - STEP : ai_target;
    end
  end

  always_ff @(posedge clk65MHz) begin
    if (rst) begin
      vblnk_q        <= 1'b0;
      strobe_armed   <= 1'b0;
      pos_valid      <= 1'b0;
      mode           <= IDLE;
      p1_ypos        <= POS_C;
      p2_ypos        <= POS_C;
      hold           <= POS_C;
      cnt            <= '0;
      remote_timeout <= 1'b0;
    end else begin
      vblnk_q   <= vblnk;
      pos_valid <= strobe;
      if (!vblnk) strobe_armed <= 1'b1;
      if (remote_valid && mode == MULTI) hold <= remote_pos;

      if (strobe) begin
        mode <= mode_next;
        if (mode_next != mode) begin
          p1_ypos        <= POS_C;
          p2_ypos        <= POS_C;
          cnt            <= '0;
          remote_timeout <= 1'b0;
        end else begin
          case (mode)
            IDLE: begin
              p1_ypos <= POS_C;
              p2_ypos <= POS_C;
            end
            SINGLE: begin
              p1_ypos <= clamp(mouse_ypos);
              p2_ypos <= ai_next;
            end
            default: begin
              p1_ypos <= clamp(mouse_ypos);
              if (remote_valid) begin
                p2_ypos <= clamp({2'b00, remote_pos});
              end else begin
                if (cnt < T_MAX) cnt <= cnt + 1'b1;
                if (timeout_hit) remote_timeout <= 1'b1;
                else             p2_ypos <= clamp({2'b00, hold});
              end
            end
          endcase
        end
      end

      if (remote_valid) begin
        cnt            <= '0;
        remote_timeout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_racket_pos_ctl.sv
// Scoreboard bench for racket_pos_ctl: frames push expected outputs, a monitor
// pops and compares on every pos_valid pulse.
module tb_racket_pos_ctl;

  typedef struct packed {
    logic [9:0] p1;
    logic [9:0] p2;
    logic [1:0] md;
    logic       to;
  } exp_t;

  logic        clk65MHz = 1'b0;
  logic        rst;
  logic        vblnk;
  logic [11:0] mouse_ypos;
  logic [9:0]  remote_pos;
  logic        remote_valid;
  logic        screen_idle;
  logic        screen_single;
  logic [9:0]  ball_ypos;
  logic [9:0]  p1_ypos;
  logic [9:0]  p2_ypos;
  logic        pos_valid;
  logic        remote_timeout;
  logic [1:0]  mode;

  int   tests = 0;
  int   fails = 0;
  exp_t q[$];

  always #8 clk65MHz = ~clk65MHz;

  racket_pos_ctl dut (
    .clk65MHz      (clk65MHz),
    .rst           (rst),
    .vblnk         (vblnk),
    .mouse_ypos    (mouse_ypos),
    .remote_pos    (remote_pos),
    .remote_valid  (remote_valid),
    .screen_idle   (screen_idle),
    .screen_single (screen_single),
    .ball_ypos     (ball_ypos),
    .p1_ypos       (p1_ypos),
    .p2_ypos       (p2_ypos),
    .pos_valid     (pos_valid),
    .remote_timeout(remote_timeout),
    .mode          (mode)
  );

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  always @(negedge clk65MHz) begin
    exp_t e;
    if (!rst && pos_valid) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pos_valid: got pulse expected none at %0t", $time);
      end else begin
        e = q.pop_front();
        chk("sb_mode", int'(mode), int'(e.md));
        chk("sb_p1", int'(p1_ypos), int'(e.p1));
        chk("sb_p2", int'(p2_ypos), int'(e.p2));
        chk("sb_timeout", int'(remote_timeout), int'(e.to));
      end
    end
  end

  // One frame: rising vblnk for one cycle, optional coincident remote update.
  task automatic frame(input logic rv, input logic [9:0] rp,
                       input int e1, input int e2, input int em, input int et);
    exp_t e;
    e.p1 = 10'(e1);
    e.p2 = 10'(e2);
    e.md = 2'(em);
    e.to = 1'(et);
    q.push_back(e);
    @(negedge clk65MHz);
    vblnk        = 1'b1;
    remote_valid = rv;
    remote_pos   = rp;
    @(negedge clk65MHz);
    vblnk        = 1'b0;
    remote_valid = 1'b0;
    @(negedge clk65MHz);
    chk("pos_valid_one_cycle", int'(pos_valid), 0);
    repeat (2) @(negedge clk65MHz);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    vblnk         = 1'b1;
    mouse_ypos    = 12'd0;
    remote_pos    = 10'd0;
    remote_valid  = 1'b0;
    screen_idle   = 1'b0;
    screen_single = 1'b0;
    ball_ypos     = 10'd384;
    repeat (3) @(negedge clk65MHz);
    rst = 1'b0;
    repeat (4) @(negedge clk65MHz);
    chk("rst_mode", int'(mode), 0);
    chk("rst_p1", int'(p1_ypos), 344);
    chk("rst_p2", int'(p2_ypos), 344);
    chk("rst_pos_valid", int'(pos_valid), 0);
    chk("rst_timeout", int'(remote_timeout), 0);
    vblnk = 1'b0;
    repeat (2) @(negedge clk65MHz);

    // enter SINGLE
    screen_single = 1'b1;
    frame(1'b0, 10'd0, 344, 344, 1, 0);

    // mouse clamping, ball at 384 keeps AI target equal to 344
    mouse_ypos = 12'd10;   frame(1'b0, 10'd0, 51, 344, 1, 0);
    mouse_ypos = 12'd700;  frame(1'b0, 10'd0, 637, 344, 1, 0);
    mouse_ypos = 12'd300;  frame(1'b0, 10'd0, 300, 344, 1, 0);
    mouse_ypos = 12'hFFF;  frame(1'b0, 10'd0, 637, 344, 1, 0);
    mouse_ypos = 12'd300;  frame(1'b0, 10'd0, 300, 344, 1, 0);

    // AI tracking toward 460, then stable
    ball_ypos = 10'd500;
    for (int k = 1; k <= 31; k++) begin
      int ev;
      ev = 344 + 4 * k;
      if (ev > 460) ev = 460;
      frame(1'b0, 10'd0, 300, ev, 1, 0);
    end
    // ball above RACKET_H/2: target is Y_MIN
    ball_ypos = 10'd10;
    frame(1'b0, 10'd0, 300, 456, 1, 0);
    frame(1'b0, 10'd0, 300, 452, 1, 0);

    // enter MULTI
    screen_single = 1'b0;
    frame(1'b0, 10'd0, 344, 344, 2, 0);
    frame(1'b1, 10'd600, 300, 600, 2, 0);
    frame(1'b1, 10'd5, 300, 51, 2, 0);
    @(negedge clk65MHz);
    remote_valid = 1'b1;
    remote_pos   = 10'd200;
    @(negedge clk65MHz);
    remote_valid = 1'b0;
    remote_pos   = 10'd0;
    frame(1'b0, 10'd0, 300, 200, 2, 0);

    // link loss: 63 quiet frames already counts one above, so 62 more then the hit
    for (int k = 2; k <= 66; k++)
      frame(1'b0, 10'd0, 300, 200, 2, (k >= 64) ? 1 : 0);
    chk("timeout_set", int'(remote_timeout), 1);
    @(negedge clk65MHz);
    remote_valid = 1'b1;
    remote_pos   = 10'd250;
    @(negedge clk65MHz);
    remote_valid = 1'b0;
    chk("timeout_clear", int'(remote_timeout), 0);
    chk("p2_before_strobe", int'(p2_ypos), 200);
    frame(1'b0, 10'd0, 300, 250, 2, 0);

    // mode inputs toggled between strobes are ignored
    screen_idle = 1'b1;   @(negedge clk65MHz);
    screen_single = 1'b1; @(negedge clk65MHz);
    screen_idle = 1'b0;   @(negedge clk65MHz);
    screen_single = 1'b0; @(negedge clk65MHz);
    chk("midframe_mode", int'(mode), 2);
    chk("midframe_p1", int'(p1_ypos), 300);
    chk("midframe_p2", int'(p2_ypos), 250);
    screen_idle = 1'b1;
    frame(1'b0, 10'd0, 344, 344, 0, 0);
    mouse_ypos = 12'd100;
    frame(1'b0, 10'd0, 344, 344, 0, 0);
    screen_single = 1'b1;
    frame(1'b0, 10'd0, 344, 344, 0, 0);

    // reset in the middle of a frame, released with vblnk high
    screen_idle = 1'b0;
    frame(1'b0, 10'd0, 344, 344, 1, 0);
    frame(1'b0, 10'd0, 100, 340, 1, 0);
    @(negedge clk65MHz);
    rst   = 1'b1;
    vblnk = 1'b1;
    repeat (2) @(negedge clk65MHz);
    rst = 1'b0;
    repeat (4) @(negedge clk65MHz);
    chk("abort_mode", int'(mode), 0);
    chk("abort_p1", int'(p1_ypos), 344);
    chk("abort_pos_valid", int'(pos_valid), 0);
    vblnk = 1'b0;
    @(negedge clk65MHz);
    frame(1'b0, 10'd0, 344, 344, 1, 0);

    repeat (5) @(negedge clk65MHz);
    chk("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
